// File: rtl/sm_seq_multiplier.sv
// Sequential sign-magnitude multiplier: shift-and-add over the magnitudes,
// one partial product per CALC cycle, with the sign resolved separately.
module sm_seq_multiplier #(
  parameter int unsigned WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned MW = WIDTH - 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [MW-1:0] mcand;
  logic [MW-1:0] mplr;
  logic [MW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          sign;

  logic [MW:0]     sum_c;
  logic [MW-1:0]   acc_nx_c;
  logic [MW-1:0]   mplr_nx_c;
  logic [2*MW-1:0] mag_c;

  // One shift-add step; the add carry becomes the new accumulator MSB.
  always_comb begin
    sum_c     = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : (MW+1)'(0));
    acc_nx_c  = sum_c[MW:1];
    mplr_nx_c = {sum_c[0], mplr[MW-1:1]};
    mag_c     = {acc_nx_c, mplr_nx_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a[MW-1:0];
            mplr  <= b[MW-1:0];
            acc   <= '0;
            sign  <= a[WIDTH-1] ^ b[WIDTH-1];
            cnt   <= CW'(MW);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_nx_c;
          mplr <= mplr_nx_c;
          cnt  <= cnt - CW'(1);
          // Last step: capture the finished product; a zero magnitude is never negative.
          if (cnt == CW'(1)) begin
            product <= {sign & (|mag_c), 1'b0, mag_c};
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_seq_multiplier.sv
// Self-checking bench for sm_seq_multiplier (WIDTH=6): directed table,
// random operands against an arithmetic model, reset abort and back-to-back runs.
module tb_sm_seq_multiplier;

  localparam int unsigned W = 6;
  localparam int unsigned NB2B = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[8];

  sm_seq_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Sign-magnitude product from plain integer arithmetic.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned mag;
    logic        s;
    mag = 32'(x[W-2:0]) * 32'(y[W-2:0]);
    s   = (mag != 0) && (x[W-1] != y[W-1]);
    return {s, (2*W-1)'(mag)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after the accepting edge; checks latency, busy length, product and pulse width.
  task automatic wait_result(input logic [2*W-1:0] exp, input string tag);
    int edges;
    int busy_cyc;
    edges    = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cyc++;
    end
    check({tag, " latency"}, 32'(edges), 32'(W));
    check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(W-1));
    check({tag, " product"}, 32'(product), 32'(exp));
    @(posedge clk); #1;
    check({tag, " done_width"}, 32'(done), 32'd0);
    check({tag, " product_hold"}, 32'(product), 32'(exp));
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                        input logic [2*W-1:0] exp, input string tag);
    @(negedge clk);
    a = ta;
    b = tb_in;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    wait_result(exp, tag);
  endtask

  initial begin
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [W-1:0]   qa[NB2B];
    logic [W-1:0]   qb[NB2B];
    logic [2*W-1:0] prev;
    int             pulses;
    int             idx;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{a: 6'b000011, b: 6'b000101, p: 12'h00F};
    vecs[1] = '{a: 6'b100111, b: 6'b001001, p: 12'h83F};
    vecs[2] = '{a: 6'b100111, b: 6'b101001, p: 12'h03F};
    vecs[3] = '{a: 6'b111111, b: 6'b011111, p: 12'hBC1};
    vecs[4] = '{a: 6'b100000, b: 6'b100101, p: 12'h000};
    vecs[5] = '{a: 6'b000000, b: 6'b000000, p: 12'h000};
    vecs[6] = '{a: 6'b011111, b: 6'b011111, p: 12'h3C1};
    vecs[7] = '{a: 6'b100001, b: 6'b000001, p: 12'h801};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset product", 32'(product), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, model(ra, rb), $sformatf("rand%0d", i));
    end

    // Reset in the third CALC cycle aborts the operation.
    prev = product;
    check("pre_abort product nonzero", 32'(prev != '0), 32'd1);
    @(negedge clk);
    a = 6'b000011;
    b = 6'b000101;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort product", 32'(product), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort no_done", 32'(done), 32'd0);
    end
    // Start already high when reset drops: accepted at the first edge.
    @(negedge clk);
    a = 6'b100111;
    b = 6'b101001;
    start = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("post_reset busy", 32'(busy), 32'd1);
    wait_result(12'h03F, "post_reset");

    // Start held high, operands changed mid-CALC.
    for (int k = 0; k < NB2B; k++) begin
      qa[k] = W'($urandom);
      qb[k] = W'($urandom);
    end
    qa[1] = 6'b111111;
    qb[1] = 6'b111111;
    @(negedge clk);
    a = qa[0];
    b = qb[0];
    start = 1'b1;
    @(posedge clk); #1;
    pulses = 0;
    for (int t = 1; t <= 7*NB2B - 1; t++) begin
      @(posedge clk); #1;
      if (t % 7 == 2) begin
        if (t/7 + 1 < NB2B) begin
          a = qa[t/7 + 1];
          b = qb[t/7 + 1];
        end else begin
          start = 1'b0;
          a = W'($urandom);
          b = W'($urandom);
        end
      end
      if (done) begin
        idx = t / 7;
        check("b2b phase", 32'(t % 7), 32'd6);
        if (idx < NB2B) check($sformatf("b2b product%0d", idx), 32'(product), 32'(model(qa[idx], qb[idx])));
        pulses++;
      end
    end
    check("b2b pulses", 32'(pulses), 32'(NB2B));
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("final idle busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_seq_multiplier.md
SM_SEQ_MULTIPLIER -- requirements
Module: sm_seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the operand width in sign-magnitude form (bit WIDTH-1 sign, bits WIDTH-2:0 magnitude).
REQ-002 The block SHALL have a single clock and an asynchronous, active-high reset, with ports as follows.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to multiply a by b; sampled only in IDLE.
REQ-006 a  input  WIDTH  multiplicand, sign-magnitude.
REQ-007 b  input  WIDTH  multiplier, sign-magnitude.
REQ-008 busy  output  1  high from start acceptance until the product is registered.
REQ-009 done  output  1  one-cycle pulse; product valid.
REQ-010 product  output  2*WIDTH  bit 2*WIDTH-1 = sign; bits 2*WIDTH-2:0 = zero-extended magnitude.

Function
REQ-011 The controller SHALL be an FSM with states IDLE, CALC and DONE.
REQ-012 In IDLE with start=1 at a rising edge: capture |a| into the multiplicand register and |b| into the multiplier register; clear the accumulator; latch sign = a[WIDTH-1] XOR b[WIDTH-1]; load counter = WIDTH-1; go to CALC.
REQ-013 Each CALC cycle: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half, keeping the carry.
REQ-014 Each CALC cycle, after any add: shift {carry, accumulator, multiplier} right by one and decrement the counter.
REQ-015 CALC SHALL run exactly WIDTH-1 cycles, then go to DONE at the edge where the counter reaches 0, registering product on that same edge.
REQ-016 The product magnitude SHALL be the exact (2*WIDTH-2)-bit unsigned product of the magnitudes; bit 2*WIDTH-2 SHALL always be 0.
REQ-017 A zero-magnitude result SHALL force the sign bit to 0; the block never outputs negative zero.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency: start accepted at edge E means product is valid and done=1 for the cycle following edge E+WIDTH; for WIDTH=6, done is high after edge E+6.
REQ-020 busy SHALL be 1 in CALC and 0 in IDLE and DONE.
REQ-021 Changes on start, a or b while in CALC or DONE SHALL be ignored; operands are used only as captured.
REQ-022 If start is held high continuously, a new operation SHALL be accepted at the first IDLE edge after DONE; the back-to-back period is WIDTH+1 cycles.
REQ-023 product SHALL hold its value until the next DONE entry and is unaffected by new start acceptance.

Reset
REQ-024 When rst=1, the FSM SHALL go to IDLE immediately, asynchronously, regardless of clk.
REQ-025 rst=1 SHALL clear product, done, busy, the counter, the accumulator and the operand registers to 0.
REQ-026 A reset asserted mid-CALC SHALL abort the operation with no done pulse; product reads 0.
REQ-027 After rst deasserts, the block SHALL accept start at the first rising edge.

Verification (WIDTH=6)
REQ-028 a=6'b000011 (+3), b=6'b000101 (+5), start pulse -> done after 6 edges, product=12'h00F, busy high for 5 cycles.
REQ-029 a=6'b100111 (-7), b=6'b001001 (+9) -> product=12'h83F (sign 1, magnitude 63); a=-7, b=-9 -> product=12'h03F.
REQ-030 a=6'b111111 (-31), b=6'b011111 (+31) -> product=12'hBC1 (magnitude 961), checking that the carry is not lost.
REQ-031 a=6'b100000 (-0), b=6'b100101 (-5) -> product=12'h000 (no negative zero).
REQ-032 Assert rst during the third CALC cycle -> outputs 0 immediately, no done pulse; the next start operates normally.
REQ-033 Hold start high and change a/b mid-CALC -> results match the captured operands, and done pulses repeat every 7 cycles.
